// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement controller.
// Holds direction and FSM state encodings, playfield limits, segment width.
// Also provides the direction-reversal helper used for turn filtering.
package snake_pkg;

  localparam int SEG_W   = 10;   // width of one coordinate / body segment field
  localparam int FIELD_W = 640;  // playfield x range 0..639
  localparam int FIELD_H = 480;  // playfield y range 0..479

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Opposite directions differ only in the upper encoding bit.
  function automatic dir_t rev_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/move_timer.sv
// Purpose: step timer; pulses tick once every TICK_DIV enabled cycles.
// Latency: tick is combinational from the count, asserted on count TICK_DIV-1.
// Backpressure: none; count is cleared whenever en is low.
// Ports: vga_clk (clock), rst_n (sync active-low reset), en (count enable), tick (step pulse).
module move_timer #(
  parameter int TICK_DIV = 6250000
) (
  input  logic vga_clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TICK_DIV - 1));

  // Holding the count at zero while disabled gives a full period after RUN entry.
  always_ff @(posedge vga_clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Purpose: snake game movement FSM (IDLE/RUN/OVER), head stepping, body history, score.
// Latency: head/body/score update on the edge closing the move_tick cycle; flags registered.
// Backpressure: none; direction/eat inputs are sampled, hazard overrides a same-cycle step.
// Ports: vga_clk, rst_n (sync active-low), start, dir_req/dir_valid, eat, hazard in;
//        snakex/snakey head, storex/storey body (segment 0 newest), score, move_tick,
//        running, over out.
// Config: define WRAP_EN to wrap the head at the playfield edges instead of ending the game.
module snake_move_ctrl import snake_pkg::*; #(
  parameter int TICK_DIV = 6250000,
  parameter int STEP     = 20,
  parameter int MAX_SEG  = 20,
  parameter int START_X  = 320,
  parameter int START_Y  = 240
) (
  input  logic                     vga_clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               dir_req,
  input  logic                     dir_valid,
  input  logic                     eat,
  input  logic                     hazard,
  output logic [SEG_W-1:0]         snakex,
  output logic [SEG_W-1:0]         snakey,
  output logic [SEG_W*MAX_SEG-1:0] storex,
  output logic [SEG_W*MAX_SEG-1:0] storey,
  output logic [7:0]               score,
  output logic                     move_tick,
  output logic                     running,
  output logic                     over
);

  localparam int STORE_W = SEG_W * MAX_SEG;
  localparam logic [SEG_W-1:0] STEP_V  = SEG_W'(STEP);
  localparam logic [SEG_W-1:0] X_LAST  = SEG_W'(FIELD_W - 1);
  localparam logic [SEG_W-1:0] Y_LAST  = SEG_W'(FIELD_H - 1);
  localparam logic [SEG_W-1:0] X_WRAP  = SEG_W'(FIELD_W - STEP);
  localparam logic [SEG_W-1:0] Y_WRAP  = SEG_W'(FIELD_H - STEP);
  localparam logic [SEG_W-1:0] X_INIT  = SEG_W'(START_X);
  localparam logic [SEG_W-1:0] Y_INIT  = SEG_W'(START_Y);
  localparam logic [7:0]       SCORE_MAX = 8'(MAX_SEG);
`ifdef WRAP_EN
  localparam logic WALL_STOP = 1'b0;
`else
  localparam logic WALL_STOP = 1'b1;
`endif

  state_t           state, state_nx;
  dir_t             cur_dir, pend_dir, move_dir;
  logic             grow;
  logic             dir_acc, restart, step_ok, wall, timer_en;
  logic [SEG_W-1:0] nx, ny;

  assign timer_en = (state == ST_RUN);

  move_timer #(.TICK_DIV(TICK_DIV)) u_move_timer (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (timer_en),
    .tick    (move_tick)
  );

  // A reversal is judged against the direction actually being travelled,
  // and a request arriving on the tick cycle still steers that tick.
  assign dir_acc  = dir_valid && (dir_t'(dir_req) != rev_dir(cur_dir));
  assign move_dir = dir_acc ? dir_t'(dir_req) : pend_dir;
  assign restart  = (state == ST_OVER) && start;
  assign step_ok  = (state == ST_RUN) && move_tick && !hazard && !wall;

  // Candidate head position. Underflow past 0 wraps to a large 10-bit value,
  // so a single "> last" compare catches leaving the field on either side.
  always_comb begin
    nx   = snakex;
    ny   = snakey;
    wall = 1'b0;
    unique case (move_dir)
      DIR_UP: begin
        ny = snakey - STEP_V;
        if (ny > Y_LAST) begin wall = WALL_STOP; ny = Y_WRAP; end
      end
      DIR_RIGHT: begin
        nx = snakex + STEP_V;
        if (nx > X_LAST) begin wall = WALL_STOP; nx = '0; end
      end
      DIR_DOWN: begin
        ny = snakey + STEP_V;
        if (ny > Y_LAST) begin wall = WALL_STOP; ny = '0; end
      end
      DIR_LEFT: begin
        nx = snakex - STEP_V;
        if (nx > X_LAST) begin wall = WALL_STOP; nx = X_WRAP; end
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (hazard || (move_tick && wall)) state_nx = ST_OVER;
      ST_OVER: if (start) state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      over    <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == ST_RUN);
      over    <= (state_nx == ST_OVER);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n || restart) begin
      snakex   <= X_INIT;
      snakey   <= Y_INIT;
      storex   <= '0;
      storey   <= '0;
      score    <= '0;
      cur_dir  <= DIR_RIGHT;
      pend_dir <= DIR_RIGHT;
      grow     <= 1'b0;
    end else if (state == ST_RUN) begin
      if (dir_acc) pend_dir <= dir_t'(dir_req);
      if (eat)     grow     <= 1'b1;
      if (step_ok) begin
        cur_dir  <= move_dir;
        pend_dir <= move_dir;
        snakex   <= nx;
        snakey   <= ny;
        storex   <= {storex[STORE_W-SEG_W-1:0], snakex};
        storey   <= {storey[STORE_W-SEG_W-1:0], snakey};
        if (grow || eat) score <= (score < SCORE_MAX) ? score + 8'd1 : score;
        grow     <= 1'b0;
      end
    end
  end

endmodule
